fifo_read_streamer: RTL and testbench

FIFO_READ_STREAMER -- requirements
Module: fifo_read_streamer

---
 rtl/fifo_rd_pkg.sv | 15 +
 rtl/rd_skid_buffer.sv | 73 +++++++
 rtl/fifo_read_streamer.sv | 87 ++++++++
 tb/tb_fifo_read_streamer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: types and constants shared by the FIFO read streamer and its
// output buffer.
package fifo_rd_pkg;

  // Output buffer occupancy; the encoding doubles as the word count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Width of the optional delivered-word counter.
  localparam int CNT_WIDTH = 16;

endpackage

// File: rtl/rd_skid_buffer.sv
// rd_skid_buffer: two-entry in-order output buffer. The head register drives
// the stream data directly. A second register holds the word that arrived
// while the head was still waiting for the sink.
module rd_skid_buffer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [DATA_WIDTH-1:0] o_head,
  output occ_e                  o_occ
);

  occ_e                  r_occ;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  // Occupancy and entry update; flush wins over any push or pop.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block sees the pre-edge values of its neighbours (r_head <= r_tail).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_occ  <= EMPTY;
      // NOTE: the data registers are reset as well, because the stream data must
      // read zero while reset is held, not just be marked invalid.
      r_head <= '0;
      r_tail <= '0;
    end else if (i_flush) begin
      r_occ <= EMPTY;
    end else begin
      case (r_occ)
        EMPTY: begin
          if (i_push) begin
            r_head <= i_push_data;
            r_occ  <= ONE;
          end
        end
        ONE: begin
          if (i_push && i_pop) begin
            r_head <= i_push_data;
          end else if (i_push) begin
            r_tail <= i_push_data;
            r_occ  <= TWO;
          end else if (i_pop) begin
            r_occ <= EMPTY;
          end
        end
        TWO: begin
          // A push without a pop cannot happen here: the requester never lets
          // buffered plus in-flight words exceed two.
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) begin
              r_tail <= i_push_data;
            end else begin
              r_occ <= ONE;
            end
          end
        end
        default: r_occ <= EMPTY;
      endcase
    end
  end

  assign o_head = r_head;
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: converts a FIFO read port with one-cycle read latency
// into a valid/ready stream. Two buffer slots absorb the in-flight word, so
// the streamer can sustain one word per cycle and still honour back-pressure.
// Optional feature: define FIFO_RD_STREAM_CNT_EN to add the pop_cnt output,
// a wrapping count of delivered stream handshakes.
module fifo_read_streamer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_r_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  pop_cnt
`endif
);

  occ_e                  w_occ;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_pop;
  logic [2:0]            w_level;
  logic                  w_room;
  logic                  r_inflight;
  logic                  r_run;

  assign w_pop   = m_valid && m_ready;
  // Words already committed: buffered plus the one on its way from the FIFO.
  assign w_level = {1'b0, w_occ} + {2'b00, r_inflight};
  // A word leaving this cycle frees its slot for a request issued now.
  assign w_room  = (w_level - {2'b00, w_pop}) < 3'd2;

  assign fifo_r_en = r_run && !fifo_empty && !flush && w_room;

  // Run enable and in-flight flag: r_run only rises on the first edge after
  // reset release, so no pop request can appear while reset is deasserting.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_run      <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= fifo_r_en && !flush;
    end
  end

  rd_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .i_clk       (rclk),
    .i_rst       (rrst),
    .i_push      (r_inflight),
    .i_push_data (fifo_rdata),
    .i_pop       (w_pop),
    .i_flush     (flush),
    .o_head      (w_head),
    .o_occ       (w_occ)
  );

  assign m_valid = (w_occ != EMPTY);
  assign m_data  = w_head;
  assign busy    = m_valid || r_inflight;

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] r_pop_cnt;

  // Delivered-word count; flush leaves it alone, only reset clears it.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_pop_cnt <= '0;
    end else if (w_pop) begin
      r_pop_cnt <= r_pop_cnt + CNT_WIDTH'(1);
    end
  end

  assign pop_cnt = r_pop_cnt;
`endif

endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb_fifo_read_streamer: directed stimulus against a behavioural FIFO with
// one-cycle read latency. Words popped from the FIFO are queued as expected
// stream data; a monitor compares every stream handshake against that queue.
module tb_fifo_read_streamer;
  import fifo_rd_pkg::*;

  localparam int DW = 8;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_r_en;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          busy;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] pop_cnt;
`endif

  fifo_read_streamer #(
    .DATA_WIDTH (DW)
  ) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_r_en  (fifo_r_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .pop_cnt    (pop_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_deliv  = 0;
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  logic          s_ren, s_valid, s_flush;
  logic          gap_en = 1'b0;
  logic          gap = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected word.
  always @(negedge rclk) begin
    if (!rrst && m_valid && m_ready) begin
      n_deliv++;
      if (exp_q.size() == 0) check("stream_extra_word", 32'(exp_q.size()), 32'd1);
      else                   check("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
  end

  // One clock cycle: sample the DUT at the falling edge, then model the FIFO
  // just after the rising edge (read data follows an accepted pop by a cycle).
  task automatic cycle();
    @(negedge rclk);
    s_ren   = fifo_r_en;
    s_valid = m_valid;
    s_flush = flush;
    @(posedge rclk);
    #1;
    if (s_flush) exp_q.delete();
    if (s_ren) begin
      fifo_rdata = src_q.pop_front();
      exp_q.push_back(fifo_rdata);
    end
    if (gap_en) gap = !gap;
    fifo_empty = (src_q.size() == 0) || (gap_en && gap);
  endtask

  task automatic load(input logic [DW-1:0] w);
    src_q.push_back(w);
    fifo_empty = (src_q.size() == 0) || (gap_en && gap);
  endtask

  task automatic assert_reset(input string tag);
    rrst = 1'b1;
    #1;
    check({tag, "_rst_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_rst_busy"}, 32'(busy), 32'd0);
    check({tag, "_rst_r_en"}, 32'(fifo_r_en), 32'd0);
    check({tag, "_rst_m_data"}, 32'(m_data), 32'd0);
    exp_q.delete();
    src_q.delete();
    fifo_empty = 1'b1;
    flush = 1'b0;
  endtask

  task automatic release_reset(input string tag);
    cycle();
    cycle();
    rrst = 1'b0;
    #1;
    check({tag, "_release_r_en"}, 32'(fifo_r_en), 32'd0);
  endtask

  initial begin
    int first_ren, first_valid, n_ren, d0;

    // Reset with data waiting: no pop request until after release.
    assert_reset("t0");
    load(8'h11); load(8'h22); load(8'h33);
    m_ready = 1'b1;
    release_reset("t0");

    // Streaming at full rate, two-cycle latency.
    first_ren = -1; first_valid = -1; d0 = n_deliv;
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (s_ren && first_ren < 0) first_ren = n;
      if (s_valid && first_valid < 0) first_valid = n;
    end
    check("t1_first_ren_seen", 32'(first_ren >= 0), 32'd1);
    check("t1_latency", 32'(first_valid - first_ren), 32'd2);
    check("t1_delivered", 32'(n_deliv - d0), 32'd3);

    // Back-pressure: two pops fill the buffer, then requests stop.
    m_ready = 1'b0;
    load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4);
    n_ren = 0;
    repeat (8) begin
      cycle();
      if (s_ren) n_ren++;
    end
    check("t2_pop_count", 32'(n_ren), 32'd2);
    check("t2_r_en_low", 32'(fifo_r_en), 32'd0);
    check("t2_m_valid", 32'(m_valid), 32'd1);
    check("t2_m_data_hold", 32'(m_data), 32'hA1);
    check("t2_occ", 32'(dut.u_buf.r_occ), 32'(TWO));
    d0 = n_deliv;
    m_ready = 1'b1;
    repeat (12) cycle();
    check("t2_delivered", 32'(n_deliv - d0), 32'd4);

    // Flush the cycle after a pop request drops the in-flight word.
    load(8'h55); load(8'h66);
    d0 = n_deliv;
    cycle();
    check("t3_ren", 32'(s_ren), 32'd1);
    flush = 1'b1;
    cycle();
    check("t3_ren_blocked", 32'(s_ren), 32'd0);
    check("t3_m_valid", 32'(m_valid), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    flush = 1'b0;
    repeat (8) cycle();
    check("t3_delivered", 32'(n_deliv - d0), 32'd1);

    // Flush together with a pop: the popped word still counts as delivered.
    m_ready = 1'b0;
    load(8'hB1); load(8'hB2);
    repeat (5) cycle();
    d0 = n_deliv;
    m_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("t3b_m_valid", 32'(m_valid), 32'd0);
    check("t3b_busy", 32'(busy), 32'd0);
    repeat (4) cycle();
    check("t3b_delivered", 32'(n_deliv - d0), 32'd1);

    // FIFO empty flag toggling every cycle: order and count preserved.
    gap_en = 1'b1;
    for (int i = 1; i <= 8; i++) load(8'(i));
    d0 = n_deliv;
    repeat (30) cycle();
    gap_en = 1'b0;
    check("t4_delivered", 32'(n_deliv - d0), 32'd8);
    check("t4_leftover", 32'(exp_q.size()), 32'd0);

    // Reset with a full buffer acts immediately, without a clock edge.
    m_ready = 1'b0;
    load(8'hC1); load(8'hC2); load(8'hC3);
    repeat (6) cycle();
    m_ready = 1'b1;
    #1;
    check("t5_r_en_pre", 32'(fifo_r_en), 32'd1);
    check("t5_m_valid_pre", 32'(m_valid), 32'd1);
    assert_reset("t5");
    load(8'hD1);
    release_reset("t5");
    d0 = n_deliv;
    repeat (8) cycle();
    check("t5_delivered", 32'(n_deliv - d0), 32'd1);
    check("t5_leftover", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_RD_STREAM_CNT_EN
    // Counter wraps: 65537 handshakes leave a count of one.
    assert_reset("t6");
    for (int i = 0; i < 65537; i++) load(8'(i));
    m_ready = 1'b1;
    release_reset("t6");
    d0 = n_deliv;
    repeat (65537 + 10) cycle();
    check("t6_delivered", 32'(n_deliv - d0), 32'd65537);
    check("t6_pop_cnt", 32'(pop_cnt), 32'h0001);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
